// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, deglitched clock, start/8 data/odd parity/stop framing,
// and a first-word-fall-through byte FIFO with sticky parity, framing and overflow flags.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int FILT_LEN     = 4,
    parameter int TIMEOUT      = 20000,
    parameter int CHECK_PARITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PS2C,
    input  logic                  PS2D,
    input  logic                  done,
    input  logic                  clr_err,
    output logic                  rdy,
    output logic [7:0]            data,
    output logic                  shift,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  perr,
    output logic                  ferr,
    output logic                  ovf,
    output logic [1:0]            fsm_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = $clog2(FILT_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0]         FILT_LAST   = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0]         TIMEOUT_CNT = TW'(TIMEOUT);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT    = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

    logic [SYNC_STAGES-1:0] c_sync, d_sync;
    logic                   c_s, d_s;
    logic                   filt;
    logic [FW-1:0]          filt_cnt;
    state_t                 state, state_next;
    logic [7:0]             shreg;
    logic [2:0]             bitcnt;
    logic                   par_bit;
    logic [TW-1:0]          tcnt;
    logic                   timeout, par_ok, push, set_perr, set_ferr;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wptr, rptr;
    logic                   pop, full, push_ok, drop;

    assign c_s = c_sync[SYNC_STAGES-1];
    assign d_s = d_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_sync <= '1;
            d_sync <= '1;
        end else begin
            c_sync <= {c_sync[SYNC_STAGES-2:0], PS2C};
            d_sync <= {d_sync[SYNC_STAGES-2:0], PS2D};
        end
    end

    // The filtered level only follows after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt     <= 1'b1;
            filt_cnt <= '0;
            shift    <= 1'b0;
        end else begin
            shift <= 1'b0;
            if (c_s == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt     <= c_s;
                filt_cnt <= '0;
                shift    <= (c_s == 1'b0);
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign timeout   = (state != IDLE) && (tcnt == TIMEOUT_CNT);
    assign par_ok    = ^{shreg, par_bit};
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        if (shift) begin
            case (state)
                IDLE:   if (!d_s) state_next = DATA;
                DATA:   if (bitcnt == 3'd7) state_next = PARITY;
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (!d_s)                            set_ferr = 1'b1;
                    else if (CHECK_PARITY != 0 && !par_ok) set_perr = 1'b1;
                    else                                 push     = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            state_next = IDLE;
            set_ferr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bitcnt  <= '0;
            par_bit <= 1'b0;
            tcnt    <= '0;
        end else if (shift) begin
            tcnt <= '0;
            case (state)
                IDLE: begin
                    bitcnt  <= '0;
                    par_bit <= 1'b0;
                end
                DATA: begin
                    shreg[bitcnt] <= d_s;
                    bitcnt        <= bitcnt + 3'd1;
                end
                PARITY:  par_bit <= d_s;
                default: ;
            endcase
        end else if (state == IDLE || timeout) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // A full FIFO still takes a byte if the same cycle frees a slot.
    assign rdy     = (count != '0);
    assign pop     = done && rdy;
    assign full    = (count == FULL_CNT);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign data    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr <= 1'b0;
            ferr <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            perr <= set_perr | (perr & ~clr_err);
            ferr <= set_ferr | (ferr & ~clr_err);
            ovf  <= drop     | (ovf  & ~clr_err);
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frames are driven on the PS/2 pins, a queue-based model predicts bytes and flags,
// and a monitor pops and compares every byte the FIFO presents.
module tb_ps2_rx_fifo;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 300;
    localparam int HALF       = 10;

    logic clk = 1'b0, rst = 1'b0, PS2C = 1'b1, PS2D = 1'b1, clr_err = 1'b0;
    logic mon_done = 1'b0, man_done = 1'b0, done_np = 1'b0;
    logic done;
    logic rdy, shift, perr, ferr, ovf;
    logic [7:0] data;
    logic [DEPTH_LOG2:0] count;
    logic [1:0] fsm_state;
    logic rdy_np, shift_np, perr_np, ferr_np, ovf_np;
    logic [7:0] data_np;
    logic [DEPTH_LOG2:0] count_np;
    logic [1:0] fsm_state_np;

    logic [7:0] exp_q[$];
    bit exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    bit mon_en = 0;
    int pass_cnt = 0, total_cnt = 0, shift_cnt = 0;

    assign done = mon_done | man_done;

    ps2_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .SYNC_STAGES(2), .FILT_LEN(4), .TIMEOUT(TIMEOUT), .CHECK_PARITY(1)) dut (
        .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D), .done(done), .clr_err(clr_err),
        .rdy(rdy), .data(data), .shift(shift), .count(count), .perr(perr), .ferr(ferr), .ovf(ovf),
        .fsm_state(fsm_state));

    ps2_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .SYNC_STAGES(2), .FILT_LEN(4), .TIMEOUT(TIMEOUT), .CHECK_PARITY(0)) dut_np (
        .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D), .done(done_np), .clr_err(clr_err),
        .rdy(rdy_np), .data(data_np), .shift(shift_np), .count(count_np), .perr(perr_np), .ferr(ferr_np),
        .ovf(ovf_np), .fsm_state(fsm_state_np));

    // clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) if (shift) shift_cnt++;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            mon_done = 1'b0;
            if (mon_en && rst && rdy && ($urandom_range(0, 3) != 0)) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_byte: got %0h, expected none", data);
                end else begin
                    chk("pop_data", 32'(data), 32'(exp_q.pop_front()));
                end
                mon_done = 1'b1;
            end
        end
    end

    // drivers
    task automatic ps2_bit(input logic d, input bit glitch, input bit pop_on_push);
        @(negedge clk);
        PS2D = d;
        if (glitch) begin
            repeat (8) @(negedge clk);
            PS2C = 1'b0;
            repeat (2) @(negedge clk);
            PS2C = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        PS2C = 1'b0;
        if (pop_on_push) begin
            repeat (6) @(posedge clk);
            @(negedge clk);
            chk("same_cycle_pop_data", 32'(data), 32'(exp_q.pop_front()));
            man_done = 1'b1;
            @(negedge clk);
            man_done = 1'b0;
            repeat (HALF - 7) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        PS2C = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit pop_on_push);
        logic p;
        int s0;
        p  = (~^b) ^ bad_par;
        s0 = shift_cnt;
        ps2_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch, 1'b0);
        ps2_bit(p, glitch, 1'b0);
        if (bad_stop)                                      exp_ferr = 1;
        else if (bad_par)                                  exp_perr = 1;
        else if (exp_q.size() >= DEPTH && !pop_on_push)    exp_ovf  = 1;
        else                                               exp_q.push_back(b);
        ps2_bit(~bad_stop, glitch, pop_on_push);
        @(negedge clk);
        PS2D = 1'b1;
        repeat (4) @(negedge clk);
        chk("frame_shifts", 32'(shift_cnt - s0), 32'd11);
        if (!mon_en) chk("frame_count", 32'(count), 32'(exp_q.size()));
        chk("frame_perr", 32'(perr), 32'(exp_perr));
        chk("frame_ferr", 32'(ferr), 32'(exp_ferr));
        chk("frame_ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic clear_err();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_perr = 0; exp_ferr = 0; exp_ovf = 0;
        chk("clr_perr", 32'(perr), 32'd0);
        chk("clr_ferr", 32'(ferr), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !rdy) break;
            @(negedge clk);
        end
        chk("drain_model", 32'(exp_q.size()), 32'd0);
        chk("drain_rdy", 32'(rdy), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_shift", 32'(shift), 32'd0);
        chk("rst_flags", 32'({perr, ferr, ovf}), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // parity error, with and without parity checking
        send_frame(8'hAA, 1, 0, 0, 0);
        chk("np_count", 32'(count_np), 32'd1);
        chk("np_data", 32'(data_np), 32'hAA);
        chk("np_perr", 32'(perr_np), 32'd0);
        done_np = 1'b1;
        repeat (2) @(negedge clk);
        chk("np_drained", 32'(count_np), 32'd0);
        clear_err();

        // single good byte
        send_frame(8'h1C, 0, 0, 0, 0);
        chk("t1_rdy", 32'(rdy), 32'd1);
        chk("t1_data", 32'(data), 32'h1C);
        mon_en = 1;
        wait_drain();

        // framing errors: bad stop bit, then a stalled frame
        send_frame(8'h55, 0, 1, 0, 0);
        clear_err();
        b = 8'h6B;
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i], 0, 0);
        exp_ferr = 1;
        PS2D = 1'b1;
        repeat (TIMEOUT + 20) @(negedge clk);
        chk("timeout_ferr", 32'(ferr), 32'd1);
        chk("timeout_idle", 32'(fsm_state), 32'd0);
        clear_err();
        send_frame(8'h3C, 0, 0, 0, 0);
        wait_drain();

        // overflow, then a push that coincides with a pop at full
        mon_en = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0, 0);
        mon_en = 1;
        wait_drain();
        clear_err();
        mon_en = 0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 0, 0, 0);
        send_frame(8'h05, 0, 0, 0, 1);
        mon_en = 1;
        wait_drain();

        // short clock glitches
        send_frame(8'hA5, 0, 0, 1, 0);
        wait_drain();

        // randomized traffic
        for (int n = 0; n < 20; n++) begin
            b    = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 9);
            send_frame(b, kind == 0, kind == 1, $urandom_range(0, 1) == 1, 0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_drain();
        clear_err();

        // asynchronous reset mid-frame with bytes queued and perr set
        mon_en = 0;
        for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 0, 0);
        send_frame(8'h33, 1, 0, 0, 0);
        b = 8'h9E;
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i], 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_rdy", 32'(rdy), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_perr", 32'(perr), 32'd0);
        chk("arst_ferr_ovf", 32'({ferr, ovf}), 32'd0);
        chk("arst_shift", 32'(shift), 32'd0);
        exp_q.delete();
        exp_perr = 0; exp_ferr = 0; exp_ovf = 0;
        PS2D = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'hF0, 0, 0, 0, 0);
        chk("t6_data", 32'(data), 32'hF0);
        mon_en = 1;
        wait_drain();
        send_frame(8'h81, 1, 0, 0, 0);
        clear_err();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
